// File: rtl/pipe_perf_monitor_if.sv
// Trace-FIFO read port of the pipeline performance monitor.
//   valid : head entry present (FIFO non-empty)
//   ready : consumer accepts the head entry this cycle
//   pc    : PC of the head entry
//   cycle : run-cycle stamp of the head entry
// master = monitor (producer), slave = consumer (bench or debug logic).
interface pipe_perf_monitor_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) ();
  logic             valid;
  logic             ready;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cycle;

  modport master (output valid, output pc, output cycle, input ready);
  modport slave  (input valid, input pc, input cycle, output ready);
endinterface

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts run cycles and per-cycle event
// strobes, stops at a programmable cycle limit, and records a PC trace
// into a small FIFO drained by valid/ready.
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        IDLE -> RUN
//   clear_i        zero counters, flush trace, back to IDLE (beats start_i)
//   evt_i          per-cycle event strobes, one counter each
//   pc_i           PC sampled into the trace on every RUN edge
//   cnt_sel_i      event counter select; values >= NUM_EVT read 0
//   cnt_o          selected event count
//   cycle_o        run-cycle count
//   running_o      in RUN
//   done_o         in DONE
//   trace_ovf_o    sticky: a trace push was dropped on a full FIFO
//   trace          trace FIFO head (valid/ready/pc/cycle), master side
//
// state | meaning
// IDLE  | waiting for start_i; counters frozen, no trace pushes
// RUN   | counting cycles/events, one trace push per edge
// DONE  | cycle limit reached; frozen until clear_i or rst_i
module pipe_perf_monitor #(
  parameter int NUM_EVT     = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int TRACE_DEPTH = 8,
  parameter int PC_W        = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [NUM_EVT-1:0]       evt_i,
  input  logic [PC_W-1:0]          pc_i,
  input  logic [$clog2(NUM_EVT):0] cnt_sel_i,
  output logic [CNT_W-1:0]         cnt_o,
  output logic [CNT_W-1:0]         cycle_o,
  output logic                     running_o,
  output logic                     done_o,
  output logic                     trace_ovf_o,
  pipe_perf_monitor_if.master      trace
);

  localparam int SEL_W = $clog2(NUM_EVT) + 1;
  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Only meaningful when CYCLE_LIMIT != 0; the compare is gated below.
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(CYCLE_LIMIT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]   evt_cnt_q [NUM_EVT];
  logic [CNT_W-1:0]   evt_cnt_d [NUM_EVT];
  logic [PC_W-1:0]    mem_pc_q  [TRACE_DEPTH];
  logic [PC_W-1:0]    mem_pc_d  [TRACE_DEPTH];
  logic [CNT_W-1:0]   mem_cyc_q [TRACE_DEPTH];
  logic [CNT_W-1:0]   mem_cyc_d [TRACE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               ovf_q, ovf_d;

  logic in_run, limit_hit, full, pop, push_ok;

  always_comb begin
    in_run    = (state_q == ST_RUN);
    limit_hit = in_run && (CYCLE_LIMIT != 0) && (cycle_q == LIMIT_M1);
    full      = (count_q == (PTR_W+1)'(TRACE_DEPTH));
    pop       = (count_q != '0) && trace.ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_ok   = in_run && (!full || pop);

    state_d   = state_q;
    cycle_d   = cycle_q;
    evt_cnt_d = evt_cnt_q;
    mem_pc_d  = mem_pc_q;
    mem_cyc_d = mem_cyc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;

    if (clear_i) begin
      state_d  = ST_IDLE;
      cycle_d  = '0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_d[k] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) state_d = ST_RUN;
        ST_RUN:  if (limit_hit) state_d = ST_DONE;
        default: state_d = state_q;
      endcase

      if (in_run) begin
        if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
        for (int k = 0; k < NUM_EVT; k++) begin
          if (evt_i[k] && (evt_cnt_q[k] != CNT_MAX))
            evt_cnt_d[k] = evt_cnt_q[k] + CNT_W'(1);
        end
        if (!push_ok) ovf_d = 1'b1;
      end

      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok) begin
        mem_pc_d[wr_ptr_q]  = pc_i;
        mem_cyc_d[wr_ptr_q] = cycle_q;
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cycle_q  <= '0;
      for (int k = 0; k < NUM_EVT; k++) evt_cnt_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      evt_cnt_q <= evt_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  // Trace storage needs no reset: head outputs are forced to 0 while empty.
  always_ff @(posedge clk_i) begin
    mem_pc_q  <= mem_pc_d;
    mem_cyc_q <= mem_cyc_d;
  end

  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < NUM_EVT; k++) begin
      if (cnt_sel_i == SEL_W'(k)) cnt_o = evt_cnt_q[k];
    end
  end

  assign cycle_o     = cycle_q;
  assign running_o   = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign trace_ovf_o = ovf_q;
  assign trace.valid = (count_q != '0);
  assign trace.pc    = trace.valid ? mem_pc_q[rd_ptr_q]  : '0;
  assign trace.cycle = trace.valid ? mem_cyc_q[rd_ptr_q] : '0;

endmodule
